// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and forwarding control for the five-stage RV32I pipeline.
// Sequences D-cache freezes and branch redirects that wait on an I-cache fill.
module pipeline_hazard_ctrl #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [4:0]           ex_rs1,
    input  logic [4:0]           ex_rs2,
    input  logic                 ex_br_taken,
    input  logic [4:0]           mem_rd,
    input  logic                 mem_load_regfile,
    input  logic [2:0]           mem_regfilemux_sel,
    input  logic [4:0]           mem_rs2,
    input  logic                 mem_dmem_read,
    input  logic                 mem_dmem_write,
    input  logic                 dmem_resp,
    input  logic [4:0]           wb_rd,
    input  logic                 wb_load_regfile,
    input  logic                 imem_req,
    input  logic                 imem_resp,
    output logic                 pc_load,
    output logic                 if_id_load,
    output logic                 id_ex_load,
    output logic                 ex_mem_load,
    output logic                 mem_wb_load,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_bubble,
    output logic [2:0]           rs1mux_sel,
    output logic [2:0]           rs2mux_sel,
    output logic                 dcacheforwardmux_sel,
    output logic [CNT_WIDTH-1:0] stall_cycles,
    output logic [CNT_WIDTH-1:0] flush_count,
    output logic [1:0]           fsm_state
);

    typedef enum logic [1:0] {RUN = 2'd0, DFREEZE = 2'd1, FLUSH_WAIT = 2'd2} state_t;

    // regfilemux_sel_t and rs*mux_sel_t encodings
    localparam logic [2:0] RF_ALU   = 3'd0;
    localparam logic [2:0] RF_BR    = 3'd1;
    localparam logic [2:0] RF_UIMM  = 3'd2;
    localparam logic [2:0] RF_RDATA = 3'd3;
    localparam logic [2:0] RF_PC4   = 3'd4;
    localparam logic [2:0] FWD_RS   = 3'b000;
    localparam logic [2:0] FWD_BR   = 3'b001;
    localparam logic [2:0] FWD_UIMM = 3'b010;
    localparam logic [2:0] FWD_ALU  = 3'b011;
    localparam logic [2:0] FWD_WB   = 3'b100;

    state_t state, state_next, mode;
    logic   pending, pending_next;
    logic   redirect_fire;
    logic   dmiss, imiss, luse;

    function automatic logic [2:0] fwd_sel(input logic [4:0] rs, input logic [4:0] mrd,
                                           input logic mlr, input logic [2:0] msel,
                                           input logic [4:0] wrd, input logic wlr);
        logic [2:0] sel;
        sel = FWD_RS;
        if (rs != 5'd0) begin
            if (wlr && wrd == rs) sel = FWD_WB;
            // A MEM hit overrides WB only when its value already exists in MEM
            if (mlr && mrd == rs) begin
                case (msel)
                    RF_ALU:  sel = FWD_ALU;
                    RF_BR:   sel = FWD_BR;
                    RF_UIMM: sel = FWD_UIMM;
                    default: ;
                endcase
            end
        end
        return sel;
    endfunction

    assign dmiss = (mem_dmem_read | mem_dmem_write) & ~dmem_resp;
    assign imiss = imem_req & ~imem_resp;
    assign luse  = mem_load_regfile && (mem_rd != 5'd0)
                   && (mem_regfilemux_sel == RF_RDATA || mem_regfilemux_sel == RF_PC4)
                   && (mem_rd == ex_rs1 || mem_rd == ex_rs2);
    // The cycle that releases a freeze behaves like the mode it froze out of
    assign mode  = (state == DFREEZE) ? (pending ? FLUSH_WAIT : RUN) : state;

    always_comb begin
        {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b11111;
        {if_id_flush, id_ex_flush, ex_mem_bubble} = 3'b000;
        state_next    = mode;
        pending_next  = 1'b0;
        redirect_fire = 1'b0;
        if (rst) begin
            {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b00000;
            {if_id_flush, id_ex_flush, ex_mem_bubble} = 3'b111;
            state_next = RUN;
        end else if (dmiss) begin
            {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load} = 5'b00000;
            state_next   = DFREEZE;
            pending_next = (mode == FLUSH_WAIT);
        end else if (mode == FLUSH_WAIT) begin
            // Completion keys on the fetch no longer being outstanding
            if (!imiss) begin
                {if_id_flush, id_ex_flush} = 2'b11;
                redirect_fire = 1'b1;
                state_next    = RUN;
            end else begin
                {pc_load, if_id_load, id_ex_load} = 3'b000;
                ex_mem_bubble = 1'b1;
            end
        end else if (luse) begin
            {pc_load, if_id_load, id_ex_load} = 3'b000;
            ex_mem_bubble = 1'b1;
        end else if (ex_br_taken) begin
            if (!imiss) begin
                {if_id_flush, id_ex_flush} = 2'b11;
                redirect_fire = 1'b1;
            end else begin
                {pc_load, if_id_load, id_ex_load} = 3'b000;
                ex_mem_bubble = 1'b1;
                state_next    = FLUSH_WAIT;
            end
        end else if (imiss) begin
            pc_load     = 1'b0;
            if_id_flush = 1'b1;
        end
    end

    always_comb begin
        rs1mux_sel           = FWD_RS;
        rs2mux_sel           = FWD_RS;
        dcacheforwardmux_sel = 1'b0;
        if (!rst) begin
            rs1mux_sel = fwd_sel(ex_rs1, mem_rd, mem_load_regfile, mem_regfilemux_sel,
                                 wb_rd, wb_load_regfile);
            rs2mux_sel = fwd_sel(ex_rs2, mem_rd, mem_load_regfile, mem_regfilemux_sel,
                                 wb_rd, wb_load_regfile);
            dcacheforwardmux_sel = mem_dmem_write && wb_load_regfile
                                   && (wb_rd != 5'd0) && (wb_rd == mem_rs2);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            pending      <= 1'b0;
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            state   <= state_next;
            pending <= pending_next;
            if (!pc_load) stall_cycles <= stall_cycles + CNT_WIDTH'(1);
            if (redirect_fire) flush_count <= flush_count + CNT_WIDTH'(1);
        end
    end

    assign fsm_state = state;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a vector table of single-cycle cases from RUN,
// then hand-written multi-cycle sequences for freezes, deferred redirects and reset.
module tb_pipeline_hazard_ctrl;

    localparam int CW = 32;

    localparam logic [1:0] S_RUN = 2'd0;
    localparam logic [1:0] S_DF  = 2'd1;
    localparam logic [1:0] S_FW  = 2'd2;

    localparam logic [2:0] ALU = 3'd0, BRS = 3'd1, UIMM = 3'd2, RDATA = 3'd3, PC4 = 3'd4;

    // load enables {pc, if_id, id_ex, ex_mem, mem_wb}
    localparam logic [4:0] L_ALL   = 5'b11111;
    localparam logic [4:0] L_STALL = 5'b00011;
    localparam logic [4:0] L_IMISS = 5'b01111;
    localparam logic [4:0] L_NONE  = 5'b00000;
    // strobes {if_id_flush, id_ex_flush, ex_mem_bubble}
    localparam logic [2:0] F_NONE  = 3'b000;
    localparam logic [2:0] F_BUB   = 3'b001;
    localparam logic [2:0] F_IF    = 3'b100;
    localparam logic [2:0] F_REDIR = 3'b110;
    localparam logic [2:0] F_RST   = 3'b111;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic [4:0] mrd;
        logic       mlr;
        logic [2:0] msel;
        logic [4:0] mrs2;
        logic       mr;
        logic       mw;
        logic       dresp;
        logic [4:0] wbrd;
        logic       wblr;
        logic       ireq;
        logic       iresp;
    } in_t;

    typedef struct {
        string      name;
        in_t        i;
        logic [16:0] e;
    } vec_t;

    logic clk, rst;
    logic [4:0] ex_rs1, ex_rs2, mem_rd, mem_rs2, wb_rd;
    logic ex_br_taken, mem_load_regfile, mem_dmem_read, mem_dmem_write, dmem_resp;
    logic wb_load_regfile, imem_req, imem_resp;
    logic [2:0] mem_regfilemux_sel;
    logic pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load;
    logic if_id_flush, id_ex_flush, ex_mem_bubble, dcacheforwardmux_sel;
    logic [2:0] rs1mux_sel, rs2mux_sel;
    logic [CW-1:0] stall_cycles, flush_count;
    logic [1:0] fsm_state;

    logic [16:0] exp_q[$];
    vec_t        tbl[$];
    int checks = 0;
    int errors = 0;

    pipeline_hazard_ctrl #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_br_taken(ex_br_taken),
        .mem_rd(mem_rd), .mem_load_regfile(mem_load_regfile),
        .mem_regfilemux_sel(mem_regfilemux_sel), .mem_rs2(mem_rs2),
        .mem_dmem_read(mem_dmem_read), .mem_dmem_write(mem_dmem_write),
        .dmem_resp(dmem_resp), .wb_rd(wb_rd), .wb_load_regfile(wb_load_regfile),
        .imem_req(imem_req), .imem_resp(imem_resp), .pc_load(pc_load),
        .if_id_load(if_id_load), .id_ex_load(id_ex_load), .ex_mem_load(ex_mem_load),
        .mem_wb_load(mem_wb_load), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
        .ex_mem_bubble(ex_mem_bubble), .rs1mux_sel(rs1mux_sel), .rs2mux_sel(rs2mux_sel),
        .dcacheforwardmux_sel(dcacheforwardmux_sel), .stall_cycles(stall_cycles),
        .flush_count(flush_count), .fsm_state(fsm_state)
    );

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic in_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic br,
                               input logic [4:0] mrd, input logic mlr, input logic [2:0] msel,
                               input logic [4:0] mrs2, input logic mr, input logic mw,
                               input logic dresp, input logic [4:0] wbrd, input logic wblr,
                               input logic ireq, input logic iresp);
        return '{rs1, rs2, br, mrd, mlr, msel, mrs2, mr, mw, dresp, wbrd, wblr, ireq, iresp};
    endfunction

    function automatic logic [16:0] ex(input logic [4:0] ld, input logic [2:0] fl,
                                       input logic [2:0] r1, input logic [2:0] r2,
                                       input logic dcf, input logic [1:0] st);
        return {ld, fl, r1, r2, dcf, st};
    endfunction

    // driver tasks
    task automatic drive(input in_t v);
        ex_rs1 = v.rs1; ex_rs2 = v.rs2; ex_br_taken = v.br;
        mem_rd = v.mrd; mem_load_regfile = v.mlr; mem_regfilemux_sel = v.msel;
        mem_rs2 = v.mrs2; mem_dmem_read = v.mr; mem_dmem_write = v.mw;
        dmem_resp = v.dresp; wb_rd = v.wbrd; wb_load_regfile = v.wblr;
        imem_req = v.ireq; imem_resp = v.iresp;
    endtask

    // scoreboard: pop one expected vector and compare with the live outputs
    task automatic check_out(input string name);
        logic [16:0] got, want;
        got = {pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load,
               if_id_flush, id_ex_flush, ex_mem_bubble, rs1mux_sel, rs2mux_sel,
               dcacheforwardmux_sel, fsm_state};
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: no expected entry queued, got %b", name, got);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got %b expected %b (ld5 fl3 rs1 rs2 dcf st)", name, got, want);
            end
        end
    endtask

    task automatic apply(input string name, input in_t v, input logic [16:0] e);
        drive(v);
        exp_q.push_back(e);
        @(negedge clk);
        check_out(name);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string name, input logic [CW-1:0] es, input logic [CW-1:0] ef);
        checks++;
        if (stall_cycles !== es || flush_count !== ef) begin
            errors++;
            $display("FAIL %s: stall_cycles=%0d flush_count=%0d expected %0d %0d",
                     name, stall_cycles, flush_count, es, ef);
        end
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        drive(mk(5, 6, 1, 5, 1, ALU, 5, 0, 1, 1, 5, 1, 0, 0));
        @(posedge clk);
        #1;
        exp_q.push_back(ex(L_NONE, F_RST, 3'd0, 3'd0, 1'b0, S_RUN));
        @(negedge clk);
        check_out(name);
        check_cnt(name, 0, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    in_t idle;
    int  exp_stall, exp_flush;

    initial begin
        idle = mk(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0);
        rst  = 1'b1;
        drive(idle);

        // name, inputs (rs1 rs2 br | mrd mlr msel mrs2 mr mw dresp | wbrd wblr | ireq iresp), expected
        tbl.push_back('{"idle", idle, ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"fwd_mem_alu", mk(5, 0, 0, 5, 1, ALU, 0, 0, 0, 0, 5, 1, 0, 0),
                        ex(L_ALL, F_NONE, 3'd3, 0, 0, S_RUN)});
        tbl.push_back('{"fwd_wb_when_mem_nowrite", mk(5, 0, 0, 5, 0, ALU, 0, 0, 0, 0, 5, 1, 0, 0),
                        ex(L_ALL, F_NONE, 3'd4, 0, 0, S_RUN)});
        tbl.push_back('{"no_fwd_x0", mk(0, 0, 0, 0, 1, ALU, 0, 0, 0, 0, 0, 1, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"fwd_mem_br_rs2", mk(0, 6, 0, 6, 1, BRS, 0, 0, 0, 0, 0, 0, 0, 0),
                        ex(L_ALL, F_NONE, 0, 3'd1, 0, S_RUN)});
        tbl.push_back('{"fwd_mem_uimm_both", mk(7, 7, 0, 7, 1, UIMM, 0, 0, 0, 0, 0, 0, 0, 0),
                        ex(L_ALL, F_NONE, 3'd2, 3'd2, 0, S_RUN)});
        tbl.push_back('{"fwd_wb_rs2", mk(0, 8, 0, 3, 1, ALU, 0, 0, 0, 0, 8, 1, 0, 0),
                        ex(L_ALL, F_NONE, 0, 3'd4, 0, S_RUN)});
        tbl.push_back('{"no_fwd_wb_disabled", mk(9, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 9, 0, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"mem_over_wb", mk(3, 0, 0, 3, 1, BRS, 0, 0, 0, 0, 3, 1, 0, 0),
                        ex(L_ALL, F_NONE, 3'd1, 0, 0, S_RUN)});
        tbl.push_back('{"store_fwd", mk(0, 0, 0, 0, 0, ALU, 9, 0, 1, 1, 9, 1, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 1, S_RUN)});
        tbl.push_back('{"store_fwd_x0", mk(0, 0, 0, 0, 0, ALU, 0, 0, 1, 1, 0, 1, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"store_fwd_wb_off", mk(0, 0, 0, 0, 0, ALU, 9, 0, 1, 1, 9, 0, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"luse_rdata", mk(0, 7, 0, 7, 1, RDATA, 0, 1, 0, 1, 0, 0, 0, 0),
                        ex(L_STALL, F_BUB, 0, 0, 0, S_RUN)});
        tbl.push_back('{"luse_pc4_ignores_br", mk(4, 0, 1, 4, 1, PC4, 0, 0, 0, 0, 0, 0, 0, 0),
                        ex(L_STALL, F_BUB, 0, 0, 0, S_RUN)});
        tbl.push_back('{"no_luse_nowrite", mk(4, 0, 0, 4, 0, RDATA, 0, 1, 0, 1, 0, 0, 0, 0),
                        ex(L_ALL, F_NONE, 0, 0, 0, S_RUN)});
        tbl.push_back('{"redirect_imem_idle", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 0, 0),
                        ex(L_ALL, F_REDIR, 0, 0, 0, S_RUN)});
        tbl.push_back('{"redirect_imem_resp", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 1),
                        ex(L_ALL, F_REDIR, 0, 0, 0, S_RUN)});
        tbl.push_back('{"imiss_only", mk(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
                        ex(L_IMISS, F_IF, 0, 0, 0, S_RUN)});

        do_reset("reset_initial");

        exp_stall = 0;
        exp_flush = 0;
        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k].name, tbl[k].i, tbl[k].e);
            if (tbl[k].e[16] == 1'b0) exp_stall++;
            if (tbl[k].e[11] && tbl[k].e[10]) exp_flush++;
        end
        check_cnt("table_counters", CW'(exp_stall), CW'(exp_flush));

        // load-use: one stall, then the producer is forwarded from WB
        do_reset("reset_luse");
        apply("luse_stall", mk(0, 7, 0, 7, 1, RDATA, 0, 1, 0, 1, 0, 0, 0, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_RUN));
        apply("luse_release", mk(0, 7, 0, 0, 0, ALU, 0, 0, 0, 0, 7, 1, 0, 0),
              ex(L_ALL, F_NONE, 0, 3'd4, 0, S_RUN));
        check_cnt("luse_counters", 1, 0);

        // branch deferred behind a 3-cycle I-cache fill
        do_reset("reset_defer");
        apply("defer_enter", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_RUN));
        for (int k = 0; k < 2; k++)
            apply("defer_hold", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
                  ex(L_STALL, F_BUB, 0, 0, 0, S_FW));
        apply("defer_fire", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 1),
              ex(L_ALL, F_REDIR, 0, 0, 0, S_FW));
        apply("defer_after", idle, ex(L_ALL, F_NONE, 0, 0, 0, S_RUN));
        check_cnt("defer_counters", 3, 1);

        // store miss with WB-to-MEM store-data forwarding
        do_reset("reset_dmiss");
        for (int k = 0; k < 4; k++)
            apply("dmiss_freeze", mk(0, 0, 0, 0, 0, ALU, 9, 0, 1, 0, 9, 1, 0, 0),
                  ex(L_NONE, F_NONE, 0, 0, 1, (k == 0) ? S_RUN : S_DF));
        apply("dmiss_resp", mk(0, 0, 0, 0, 0, ALU, 9, 0, 1, 1, 9, 1, 0, 0),
              ex(L_ALL, F_NONE, 0, 0, 1, S_DF));
        apply("dmiss_after", idle, ex(L_ALL, F_NONE, 0, 0, 0, S_RUN));
        check_cnt("dmiss_counters", 4, 0);

        // dmiss together with a taken branch: redirect waits for the release
        do_reset("reset_dmiss_br");
        apply("dmiss_br_0", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 0, 0),
              ex(L_NONE, F_NONE, 0, 0, 0, S_RUN));
        apply("dmiss_br_1", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 0, 0),
              ex(L_NONE, F_NONE, 0, 0, 0, S_DF));
        apply("dmiss_br_release", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 1, 0, 0, 0, 0),
              ex(L_ALL, F_REDIR, 0, 0, 0, S_DF));
        check_cnt("dmiss_br_counters", 2, 1);

        // freeze during FLUSH_WAIT must return to FLUSH_WAIT
        do_reset("reset_fw_dmiss");
        apply("fwd_enter", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_RUN));
        apply("fwd_dmiss_0", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 1, 0),
              ex(L_NONE, F_NONE, 0, 0, 0, S_FW));
        apply("fwd_dmiss_1", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 0, 0, 0, 1, 0),
              ex(L_NONE, F_NONE, 0, 0, 0, S_DF));
        apply("fwd_dresp", mk(0, 0, 1, 0, 0, ALU, 0, 1, 0, 1, 0, 0, 1, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_DF));
        apply("fwd_fire", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 1),
              ex(L_ALL, F_REDIR, 0, 0, 0, S_FW));
        apply("fwd_after", idle, ex(L_ALL, F_NONE, 0, 0, 0, S_RUN));
        check_cnt("fw_dmiss_counters", 4, 1);

        // load-use hidden behind its own miss, re-evaluated after the freeze
        do_reset("reset_luse_dmiss");
        apply("luse_dmiss_freeze", mk(0, 7, 0, 7, 1, RDATA, 0, 1, 0, 0, 0, 0, 0, 0),
              ex(L_NONE, F_NONE, 0, 0, 0, S_RUN));
        apply("luse_dmiss_resp", mk(0, 7, 0, 7, 1, RDATA, 0, 1, 0, 1, 0, 0, 0, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_DF));
        apply("luse_dmiss_wb", mk(0, 7, 0, 0, 0, ALU, 0, 0, 0, 0, 7, 1, 0, 0),
              ex(L_ALL, F_NONE, 0, 3'd4, 0, S_RUN));
        check_cnt("luse_dmiss_counters", 2, 0);

        // reset mid-FLUSH_WAIT drops the pending redirect
        do_reset("reset_pre_fw");
        apply("fw_rst_enter", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_RUN));
        apply("fw_rst_hold", mk(0, 0, 1, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 0),
              ex(L_STALL, F_BUB, 0, 0, 0, S_FW));
        do_reset("reset_mid_fw");
        apply("fw_rst_no_redirect", mk(0, 0, 0, 0, 0, ALU, 0, 0, 0, 0, 0, 0, 1, 1),
              ex(L_ALL, F_NONE, 0, 0, 0, S_RUN));
        check_cnt("fw_rst_counters", 0, 0);

        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
